// File: rtl/qam_mapper_us.sv
// qam_mapper_us: bit-buffered QPSK/16/64-QAM mapper with zero-stuffed upsampling.
// Optional QAM_GRAY_EN Gray-decodes each I/Q half before level mapping.
module qam_mapper_us #(
    parameter int DIN_W = 8,
    parameter int OUT_W = 16,
    parameter int OSR   = 4,
    parameter int SCALE = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DIN_W-1:0]        din,
    input  logic                    din_valid,
    output logic                    din_ready,
    input  logic [1:0]              mode,
    output logic signed [OUT_W-1:0] dout_i,
    output logic signed [OUT_W-1:0] dout_q,
    output logic                    DOUT_VALID,
    output logic                    underrun,
    output logic                    mode_err
);
    localparam int BW = 2 * DIN_W;
    localparam int CW = $clog2(BW + 1);
    localparam int PW = (OSR > 1) ? $clog2(OSR) : 1;

    logic [BW-1:0]           r_buf;
    logic [CW-1:0]           r_cnt;
    logic [PW-1:0]           r_phase;
    logic [1:0]              r_mode;
    logic                    r_started;
    logic                    r_dv;
    logic                    r_underrun;
    logic                    r_mode_err;
    logic signed [OUT_W-1:0] r_di;
    logic signed [OUT_W-1:0] r_dq;

    logic [1:0]    w_m;
    logic [CW-1:0] w_k;
    logic [CW-1:0] w_kt;
    logic [CW-1:0] w_rem;
    logic [PW-1:0] w_ph_nxt;
    logic [5:0]    w_top;
    logic [2:0]    w_vi;
    logic [2:0]    w_vq;
    logic [2:0]    w_gi;
    logic [2:0]    w_gq;
    logic [2:0]    w_lm1;
    logic          w_take;
    logic          w_acc;

    function automatic logic signed [OUT_W-1:0] amp(input logic [2:0] v, input logic [2:0] lm1);
        return OUT_W'(($signed({1'b0, v}) * 2 - $signed({1'b0, lm1})) * SCALE);
    endfunction

    assign din_ready  = (r_cnt <= CW'(DIN_W));
    assign dout_i     = r_di;
    assign dout_q     = r_dq;
    assign DOUT_VALID = r_dv;
    assign underrun   = r_underrun;
    assign mode_err   = r_mode_err;

    always_comb begin
        w_m      = (r_mode == 2'd3) ? 2'd0 : r_mode;
        w_k      = (w_m == 2'd0) ? CW'(2) : (w_m == 2'd1) ? CW'(4) : CW'(6);
        w_lm1    = (w_m == 2'd0) ? 3'd1 : (w_m == 2'd1) ? 3'd3 : 3'd7;
        w_top    = r_buf[BW-1 -: 6];
        w_vi     = (w_m == 2'd0) ? {2'b0, w_top[5]} : (w_m == 2'd1) ? {1'b0, w_top[5:4]} : w_top[5:3];
        w_vq     = (w_m == 2'd0) ? {2'b0, w_top[4]} : (w_m == 2'd1) ? {1'b0, w_top[3:2]} : w_top[2:0];
`ifdef QAM_GRAY_EN
        w_gi     = w_vi ^ (w_vi >> 1) ^ (w_vi >> 2);
        w_gq     = w_vq ^ (w_vq >> 1) ^ (w_vq >> 2);
`else
        w_gi     = w_vi;
        w_gq     = w_vq;
`endif
        w_take   = (r_phase == '0) && (r_cnt >= w_k);
        w_acc    = din_valid && din_ready;
        w_kt     = w_take ? w_k : '0;
        w_rem    = r_cnt - w_kt;
        w_ph_nxt = (r_phase == PW'(OSR - 1)) ? '0 : r_phase + PW'(1);
    end

    // Oldest bit sits at the buffer MSB; new words are appended just below the survivors.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_buf      <= '0;
            r_cnt      <= '0;
            r_phase    <= '0;
            r_mode     <= 2'd0;
            r_started  <= 1'b0;
            r_dv       <= 1'b0;
            r_underrun <= 1'b0;
            r_mode_err <= 1'b0;
            r_di       <= '0;
            r_dq       <= '0;
        end else begin
            r_buf <= (r_buf << w_kt) | (w_acc ? ({din, {DIN_W{1'b0}}} >> w_rem) : '0);
            r_cnt <= w_rem + (w_acc ? CW'(DIN_W) : '0);
            if (w_acc)
                r_started <= 1'b1;
            if (r_cnt == '0 && r_phase == '0) begin
                r_mode <= mode;
                if (mode == 2'd3)
                    r_mode_err <= 1'b1;
            end
            if (r_phase != '0) begin
                r_di    <= '0;
                r_dq    <= '0;
                r_dv    <= 1'b1;
                r_phase <= w_ph_nxt;
            end else if (w_take) begin
                r_di    <= amp(w_gi, w_lm1);
                r_dq    <= amp(w_gq, w_lm1);
                r_dv    <= 1'b1;
                r_phase <= w_ph_nxt;
            end else begin
                r_di <= '0;
                r_dq <= '0;
                r_dv <= 1'b0;
                if (r_started)
                    r_underrun <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_qam_mapper_us.sv
// tb_qam_mapper_us: randomized bench against a bit-queue reference model of qam_mapper_us.
module tb_qam_mapper_us;
    localparam int DW  = 8;
    localparam int OW  = 16;
    localparam int OSR = 4;
    localparam int SC  = 1024;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [DW-1:0]        din = '0;
    logic                 din_valid = 1'b0;
    logic                 din_ready;
    logic [1:0]           mode = 2'd0;
    logic signed [OW-1:0] dout_i;
    logic signed [OW-1:0] dout_q;
    logic                 DOUT_VALID;
    logic                 underrun;
    logic                 mode_err;

    int n_vec = 0;
    int n_err = 0;

    bit mq[$];
    int m_phase;
    bit m_started;
    int m_lmode;
    int e_i;
    int e_q;
    bit e_v;
    bit e_u;
    bit e_e;

    qam_mapper_us #(.DIN_W(DW), .OUT_W(OW), .OSR(OSR), .SCALE(SC)) dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .mode(mode), .dout_i(dout_i), .dout_q(dout_q), .DOUT_VALID(DOUT_VALID),
        .underrun(underrun), .mode_err(mode_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int level(input int v, input int h);
        int b = v;
`ifdef QAM_GRAY_EN
        int p = 0;
        b = 0;
        for (int i = h - 1; i >= 0; i--) begin
            p = p ^ ((v >> i) & 1);
            b = b * 2 + p;
        end
`endif
        return (2 * b - ((1 << h) - 1)) * SC;
    endfunction

    task automatic model_clear();
        mq.delete();
        m_phase = 0;
        m_started = 0;
        m_lmode = 0;
        e_i = 0;
        e_q = 0;
        e_v = 0;
        e_u = 0;
        e_e = 0;
    endtask

    task automatic model_edge(input bit v, input logic [DW-1:0] d, input logic [1:0] m);
        int cnt = mq.size();
        int h;
        int vi;
        int vq;
        bit acc;
        bit latch;
        acc = v && (cnt + DW <= 2 * DW);
        latch = (cnt == 0) && (m_phase == 0);
        h = ((m_lmode == 3) ? 0 : m_lmode) + 1;
        if (m_phase != 0) begin
            e_i = 0; e_q = 0; e_v = 1;
            m_phase = (m_phase + 1) % OSR;
        end else if (cnt >= 2 * h) begin
            vi = 0; vq = 0;
            for (int i = 0; i < h; i++) vi = vi * 2 + int'(mq.pop_front());
            for (int i = 0; i < h; i++) vq = vq * 2 + int'(mq.pop_front());
            e_i = level(vi, h); e_q = level(vq, h); e_v = 1;
            m_phase = (m_phase + 1) % OSR;
        end else begin
            e_i = 0; e_q = 0; e_v = 0;
            if (m_started) e_u = 1;
        end
        if (acc) begin
            for (int b = DW - 1; b >= 0; b--) mq.push_back(d[b]);
            m_started = 1;
        end
        if (latch) begin
            m_lmode = int'(m);
            if (m == 2'd3) e_e = 1;
        end
    endtask

    task automatic step(input bit v, input logic [DW-1:0] d, input logic [1:0] m);
        din_valid = v;
        din = d;
        mode = m;
        check("din_ready", int'(din_ready), int'(mq.size() + DW <= 2 * DW));
        @(posedge clk);
        model_edge(v, d, m);
        #1;
        check("dout_i", int'(dout_i), e_i);
        check("dout_q", int'(dout_q), e_q);
        check("dout_valid", int'(DOUT_VALID), int'(e_v));
        check("underrun", int'(underrun), int'(e_u));
        check("mode_err", int'(mode_err), int'(e_e));
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        #1;
        check("rst_dout_i", int'(dout_i), 0);
        check("rst_dout_q", int'(dout_q), 0);
        check("rst_valid", int'(DOUT_VALID), 0);
        check("rst_underrun", int'(underrun), 0);
        check("rst_mode_err", int'(mode_err), 0);
        check("rst_ready", int'(din_ready), 1);
        model_clear();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        int sent;
        logic [1:0] rm;
        model_clear();
        @(posedge clk);
        #1;
        do_reset();
        step(1, 8'hB4, 2'd1);
        repeat (12) step(0, 8'h00, 2'd1);
        do_reset();
        step(1, 8'h80, 2'd0);
        repeat (40) step(1, 8'($urandom), 2'd0);
        do_reset();
        sent = 0;
        repeat (40) begin
            if (sent < 3 && mq.size() <= DW) begin
                step(1, 8'hFF, 2'd2);
                sent++;
            end else
                step(0, 8'($urandom), 2'd2);
        end
        do_reset();
        step(1, 8'($urandom), 2'd1);
        repeat (12) step(0, 8'($urandom), 2'd1);
        do_reset();
        step(1, 8'($urandom), 2'd1);
        step(0, 8'h00, 2'd1);
        step(0, 8'h00, 2'd1);
        do_reset();
        repeat (4) step(0, 8'h00, 2'd3);
        repeat (20) step(1, 8'($urandom), 2'd3);
        do_reset();
        rm = 2'd0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 15) == 0) rm = 2'($urandom_range(0, 3));
            if (n % 700 == 699) do_reset();
            step($urandom_range(0, 4) != 0, 8'($urandom), rm);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/qam_mapper_us.md
QAM_MAPPER_US -- requirements
Module: qam_mapper_us

Interface
REQ-001 The block SHALL have parameter DIN_W, default 8: input word width in bits, an even number of at least 6.
REQ-002 The block SHALL have parameter OUT_W, default 16: signed output sample width.
REQ-003 The block SHALL have parameter OSR, default 4: upsampling factor, 1..16.
REQ-004 The block SHALL have parameter SCALE, default 1024: amplitude of one unit level step.
REQ-005 The block SHALL have port clk, input, 1 bit: sole clock; all state updates on the rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port din, input, DIN_W bits: payload word, transmitted MSB first.
REQ-008 The block SHALL have port din_valid, input, 1 bit: din is valid.
REQ-009 The block SHALL have port din_ready, output, 1 bit: block accepts din this cycle.
REQ-010 The block SHALL have port mode, input, 2 bits: constellation select; 0 = QPSK (k=2), 1 = 16-QAM (k=4), 2 = 64-QAM (k=6), 3 = reserved.
REQ-011 The block SHALL have port dout_i, output, OUT_W bits, signed: in-phase sample.
REQ-012 The block SHALL have port dout_q, output, OUT_W bits, signed: quadrature sample.
REQ-013 The block SHALL have port DOUT_VALID, output, 1 bit: dout_i and dout_q are a valid output sample.
REQ-014 The block SHALL have port underrun, output, 1 bit: sticky flag, set when a symbol slot finds too few bits.
REQ-015 The block SHALL have port mode_err, output, 1 bit: sticky flag, set when reserved mode 3 is latched.

Function
REQ-016 The block SHALL hold received bits in a 2*DIN_W-bit FIFO bit buffer with a bit count bit_cnt.
REQ-017 The block SHALL drive din_ready = (bit_cnt + DIN_W <= 2*DIN_W), using the pre-consumption count.
REQ-018 The block SHALL treat a din word as accepted on an edge where din_valid and din_ready are both 1.
REQ-019 Consumption of k bits and acceptance of DIN_W bits SHALL be allowed on the same edge, giving a net count change of DIN_W - k.
REQ-020 The block SHALL keep an output phase counter running 0..OSR-1 and wrapping to 0.
REQ-021 At phase 0 with bit_cnt >= k, the block SHALL consume the oldest k bits; the first k/2 bits form I, the next k/2 bits form Q.
REQ-022 Each half SHALL map to value v in 0..L-1, with L = 2^(k/2), and amplitude (2v - (L-1)) * SCALE.
REQ-023 Sample outputs SHALL be registered, appearing one cycle after the consuming edge with DOUT_VALID = 1.
REQ-024 In phases 1..OSR-1 the block SHALL output dout_i = dout_q = 0 with DOUT_VALID = 1 (zero-stuffing).
REQ-025 With OSR = 1, every cycle SHALL be a phase-0 cycle.
REQ-026 At phase 0 with bit_cnt < k, the block SHALL hold the phase at 0, output zeros with DOUT_VALID = 0, and set underrun.
REQ-027 Underrun SHALL only be flagged after the first accepted word since reset; an idle block that has never received data SHALL NOT set it.
REQ-028 mode SHALL be latched only when bit_cnt = 0 and phase = 0; between latches, the latched mode SHALL govern.
REQ-029 Latched mode 3 SHALL set mode_err and be treated as QPSK.
REQ-030 All amplitudes SHALL fit OUT_W without saturation at default parameters (maximum magnitude 7*1024).

Reset
REQ-031 While reset = 0, the block SHALL clear the bit buffer, bit_cnt, phase, underrun, mode_err and the first-word indicator.
REQ-032 While reset = 0, the block SHALL drive dout_i = dout_q = 0, DOUT_VALID = 0, latched mode = 0 and din_ready = 1.
REQ-033 A reset asserted mid-symbol SHALL discard all partial bits; no sample SHALL be emitted from pre-reset data after reset releases.

Configuration
REQ-034 When macro QAM_GRAY_EN is defined, each k/2-bit half SHALL be Gray-decoded before the level mapping, so adjacent levels differ by one bit.
REQ-035 When QAM_GRAY_EN is undefined, each half SHALL be mapped as a natural binary v.
REQ-036 Port list and timing SHALL be identical with and without QAM_GRAY_EN.

Verification
REQ-037 16-QAM, Gray off, OSR=4, din=8'hB4: samples SHALL be (1024,3072),0,0,0,(-1024,-3072),0,0,0, then DOUT_VALID=0.
REQ-038 Same stimulus with QAM_GRAY_EN: first symbol SHALL be (3072,1024) and second symbol (-1024,-3072).
REQ-039 QPSK, din=8'h80 then continuous valid words: first sample SHALL be (1024,-1024); no DOUT_VALID gaps; underrun SHALL stay 0.
REQ-040 64-QAM, din=8'hFF,8'hFF,8'hFF: four symbols of (7168,7168); din_ready SHALL drop whenever bit_cnt exceeds DIN_W.
REQ-041 Stall din_valid for 10 cycles after one 16-QAM word: underrun SHALL rise after two symbols; DOUT_VALID SHALL be 0 during the stall; phase SHALL hold at 0.
REQ-042 Pull reset low mid-symbol (phase 2, bit_cnt 4), then release: outputs, flags and bit_cnt SHALL all be 0 and din_ready SHALL be 1; mode 3 latched afterwards SHALL set mode_err.
